// File: rtl/video_pkg.sv
// Shared definitions for the video capture sink: resolution defaults,
// the packed RGB444 pixel and the sink state encoding.
package video_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    SINK_IDLE    = 2'd0,
    SINK_CAPTURE = 2'd1,
    SINK_DONE    = 2'd2
  } sink_state_t;

endpackage

// File: rtl/crc16_step.sv
// One CRC-16-CCITT update (poly 0x1021, MSB first) over a 12-bit RGB444 pixel.
module crc16_step (
  input  logic [15:0] crc_in,
  input  logic [11:0] data_in,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ data_in[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                    c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/video_sink.sv
// Captures one frame of a pixel stream into a framebuffer write port.
// Define VIDEO_SINK_CRC_EN to add the per-frame CRC-16 output crc_out.
//
// state        | meaning
// SINK_IDLE    | waiting for a de_in pixel at (0,0)
// SINK_CAPTURE | writing pixels, address counter running
// SINK_DONE    | one cycle after the last pixel; frame_done_out pulses
module video_sink
  import video_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [9:0]  sx_in,
  input  logic [9:0]  sy_in,
  input  logic        de_in,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic        fb_we_out,
  output logic [18:0] fb_addr_out,
  output logic [11:0] fb_data_out,
  output logic        frame_done_out,
  output logic        err_out
`ifdef VIDEO_SINK_CRC_EN
  ,
  output logic [15:0] crc_out
`endif
);

  localparam logic [18:0] FRAME_PIX = 19'(H_RES * V_RES);
  localparam logic [9:0]  COL_LAST  = 10'(H_RES - 1);

  sink_state_t state;
  logic [18:0] addr_cnt;
  logic [9:0]  col_cnt;
  logic [9:0]  row_cnt;
  logic        at_origin;
  logic        frame_full;
  logic        capture;
  logic        frame_end;
  rgb444_t     pix;
  logic        unused_lsbs;

  assign at_origin   = (sx_in == 10'd0) && (sy_in == 10'd0);
  assign frame_full  = (addr_cnt == FRAME_PIX);
  assign pix         = '{r: r_in[7:4], g: g_in[7:4], b: b_in[7:4]};
  assign unused_lsbs = ^{r_in[3:0], g_in[3:0], b_in[3:0]};

  // A pixel is taken only at (0,0) from idle, or while the frame still has room.
  assign capture   = de_in && (((state == SINK_IDLE) && at_origin) ||
                               ((state == SINK_CAPTURE) && !frame_full));
  assign frame_end = (state == SINK_CAPTURE) && !de_in && frame_full;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= SINK_IDLE;
      addr_cnt       <= '0;
      col_cnt        <= '0;
      row_cnt        <= '0;
      fb_we_out      <= 1'b0;
      fb_addr_out    <= '0;
      fb_data_out    <= '0;
      frame_done_out <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      fb_we_out      <= capture;
      frame_done_out <= 1'b0;
      if (capture) fb_data_out <= pix;

      if (capture && at_origin) begin
        // fresh frame; arriving here from CAPTURE means the last one was short
        state       <= SINK_CAPTURE;
        err_out     <= (state == SINK_CAPTURE);
        fb_addr_out <= '0;
        addr_cnt    <= 19'd1;
        col_cnt     <= 10'd1;
        row_cnt     <= '0;
      end else begin
        case (state)
          SINK_CAPTURE: begin
            if (capture) begin
              fb_addr_out <= addr_cnt;
              addr_cnt    <= addr_cnt + 19'd1;
              if ((sx_in != col_cnt) || (sy_in != row_cnt)) err_out <= 1'b1;
              if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 10'd1;
              end else begin
                col_cnt <= col_cnt + 10'd1;
              end
            end else if (de_in) begin
              err_out <= 1'b1;
            end else if (frame_end) begin
              state          <= SINK_DONE;
              frame_done_out <= 1'b1;
            end
          end
          SINK_DONE: state <= SINK_IDLE;
          default:   state <= SINK_IDLE;
        endcase
      end
    end
  end

`ifdef VIDEO_SINK_CRC_EN
  logic [15:0] crc_acc;
  logic [15:0] crc_next;

  crc16_step u_crc16_step (
    .crc_in  (at_origin ? 16'hFFFF : crc_acc),
    .data_in (pix),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      crc_acc <= 16'hFFFF;
      crc_out <= 16'hFFFF;
    end else begin
      if (capture)   crc_acc <= crc_next;
      if (frame_end) crc_out <= crc_acc;
    end
  end
`endif

endmodule

// File: tb/tb_video_sink.sv
// Randomized bench for video_sink on a reduced 16x8 frame against a pixel-index model.
module tb_video_sink;

  localparam int H     = 16;
  localparam int V     = 8;
  localparam int TOTAL = H * V;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [9:0]  sx_in;
  logic [9:0]  sy_in;
  logic        de_in;
  logic [7:0]  r_in;
  logic [7:0]  g_in;
  logic [7:0]  b_in;
  logic        fb_we_out;
  logic [18:0] fb_addr_out;
  logic [11:0] fb_data_out;
  logic        frame_done_out;
  logic        err_out;
`ifdef VIDEO_SINK_CRC_EN
  logic [15:0] crc_out;
`endif

  video_sink #(.H_RES(H), .V_RES(V)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .sx_in          (sx_in),
    .sy_in          (sy_in),
    .de_in          (de_in),
    .r_in           (r_in),
    .g_in           (g_in),
    .b_in           (b_in),
    .fb_we_out      (fb_we_out),
    .fb_addr_out    (fb_addr_out),
    .fb_data_out    (fb_data_out),
    .frame_done_out (frame_done_out),
    .err_out        (err_out)
`ifdef VIDEO_SINK_CRC_EN
    ,
    .crc_out        (crc_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: frame position is a pixel index, checked with div/mod
  bit          m_active = 0;
  bit          m_done_phase = 0;
  int          m_n = 0;
  logic        m_we = 0;
  logic [18:0] m_addr = '0;
  logic [11:0] m_data = '0;
  logic        m_done = 0;
  logic        m_err = 0;
  logic [15:0] m_crc = 16'hFFFF;
  logic [11:0] m_px[$];

  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [18:0] last_addr = '0;
  logic [23:0] frame_rgb [TOTAL];

  function automatic logic [15:0] crc_of(input logic [11:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[k])
      for (int b = 11; b >= 0; b--)
        c = (c << 1) ^ (((c >> 15) & 16'h1) != {15'd0, q[k][b]} ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  task automatic step(input logic rst, input logic de, input int x, input int y, input logic [23:0] rgb);
    logic [11:0] px;
    bit origin;
    px = {rgb[23:20], rgb[15:12], rgb[7:4]};
    origin = (x == 0) && (y == 0);
    rst_in = rst; de_in = de; sx_in = 10'(x); sy_in = 10'(y);
    {r_in, g_in, b_in} = rgb;
    @(posedge clk_in);
    m_we = 0; m_done = 0;
    if (rst) begin
      m_active = 0; m_done_phase = 0; m_n = 0; m_addr = '0; m_data = '0;
      m_err = 0; m_crc = 16'hFFFF; m_px.delete();
    end else if (m_done_phase) begin
      m_done_phase = 0;
    end else if (!m_active) begin
      if (de && origin) begin
        m_active = 1; m_err = 0; m_we = 1; m_addr = '0; m_data = px; m_n = 1; m_px = {px};
      end
    end else if (de) begin
      if (m_n == TOTAL) m_err = 1;
      else if (origin) begin
        m_err = 1; m_we = 1; m_addr = '0; m_data = px; m_n = 1; m_px = {px};
      end else begin
        if (x != m_n % H || y != m_n / H) m_err = 1;
        m_we = 1; m_addr = 19'(m_n); m_data = px; m_n++; m_px.push_back(px);
      end
    end else if (m_n == TOTAL) begin
      m_done = 1; m_crc = crc_of(m_px); m_active = 0; m_done_phase = 1;
    end
    #1;
    check_val("we", fb_we_out, m_we);
    check_val("addr", fb_addr_out, m_addr);
    check_val("data", fb_data_out, m_data);
    check_val("done", frame_done_out, m_done);
    check_val("err", err_out, m_err);
`ifdef VIDEO_SINK_CRC_EN
    check_val("crc", crc_out, m_crc);
`endif
    if (fb_we_out) begin wr_cnt++; last_addr = fb_addr_out; end
    if (frame_done_out) done_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, H + 1, V + 1, 24'h0);
  endtask

  task automatic gen_frame(input int first, input int stop, input int skip_line);
    for (int idx = first; idx < stop; idx++) begin
      int x, y, lx;
      x = idx % H; y = idx / H;
      lx = (y == skip_line && x >= 11) ? x + 1 : x;
      if ($urandom_range(0, 7) == 0) step(0, 0, $urandom_range(0, H - 1), y, $urandom);
      step(0, 1, lx, y, frame_rgb[idx]);
      if (x == H - 1) repeat (2) step(0, 0, H + 1, y, 24'h0);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < TOTAL; i++) frame_rgb[i] = 24'($urandom);
  endtask

  task automatic clr_stats();
    wr_cnt = 0; done_cnt = 0;
  endtask

  initial begin
    logic [15:0] crc_a, crc_b, crc_c;
    crc_a = '0; crc_b = '0; crc_c = '0;
    for (int i = 0; i < TOTAL; i++) frame_rgb[i] = 24'hF00FA5;
    repeat (3) step(1, 1, 0, 0, 24'hFFFFFF);
    check_val("rst_we", fb_we_out, 0);
    check_val("rst_err", err_out, 0);

    // full frame, fixed colour
    clr_stats();
    gen_frame(0, TOTAL, -1); idle(3);
    check_val("full_writes", wr_cnt, TOTAL);
    check_val("full_last_addr", last_addr, TOTAL - 1);
    check_val("full_done_cnt", done_cnt, 1);
    check_val("full_err", err_out, 0);
    check_val("full_data", fb_data_out, 12'hF0A);

    // column skip on line 5
    fill_random(); clr_stats();
    gen_frame(0, TOTAL, 5); idle(3);
    check_val("skip_err", err_out, 1);
    check_val("skip_done_cnt", done_cnt, 1);

    // short frame: (0,0) re-appears after 40 pixels
    clr_stats();
    gen_frame(0, 40, -1);
    check_val("short_no_done", done_cnt, 0);
    step(0, 1, 0, 0, frame_rgb[0]);
    check_val("short_err", err_out, 1);
    check_val("short_we", fb_we_out, 1);
    check_val("short_addr0", fb_addr_out, 0);
    gen_frame(1, TOTAL, -1); idle(3);
    check_val("short_then_done", done_cnt, 1);
    check_val("short_err_held", err_out, 1);

    // reset mid-frame
    fill_random(); clr_stats();
    gen_frame(0, 70, -1);
    step(1, 1, 6, 4, 24'hFFFFFF);
    check_val("midrst_we", fb_we_out, 0);
    check_val("midrst_addr", fb_addr_out, 0);
    check_val("midrst_err", err_out, 0);
    clr_stats();
    gen_frame(71, TOTAL, -1); idle(3);
    check_val("midrst_no_writes", wr_cnt, 0);
    check_val("midrst_no_done", done_cnt, 0);
    gen_frame(0, TOTAL, -1); idle(3);
    check_val("midrst_next_writes", wr_cnt, TOTAL);

    // stream starting mid-frame
    clr_stats();
    gen_frame(3 * H + 5, TOTAL, -1); idle(3);
    check_val("midstart_no_writes", wr_cnt, 0);
    gen_frame(0, TOTAL, -1); idle(3);
    check_val("midstart_writes", wr_cnt, TOTAL);
    check_val("midstart_done", done_cnt, 1);
    check_val("midstart_err", err_out, 0);

    // overflow: extra de at (0,0) right after the last pixel
    clr_stats();
    gen_frame(0, TOTAL - 1, -1);
    step(0, 1, H - 1, V - 1, frame_rgb[TOTAL - 1]);
    step(0, 1, 0, 0, frame_rgb[0]);
    check_val("ovf_no_write", fb_we_out, 0);
    check_val("ovf_err", err_out, 1);
    idle(3);
    check_val("ovf_writes", wr_cnt, TOTAL);
    check_val("ovf_done", done_cnt, 1);

`ifdef VIDEO_SINK_CRC_EN
    fill_random();
    gen_frame(0, TOTAL, -1); idle(3); crc_a = crc_out;
    gen_frame(0, TOTAL, -1); idle(3); crc_b = crc_out;
    check_val("crc_same", crc_b, crc_a);
    frame_rgb[17] = frame_rgb[17] ^ 24'h100000;
    gen_frame(0, TOTAL, -1); idle(3); crc_c = crc_out;
    check_val("crc_differs", crc_c != crc_a, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
